// File: rtl/address_sequencer.sv
// rtl/address_sequencer.sv - linear/list address walker for the pattern memory storage port
// One address per ready/valid handshake; list entries are read one index ahead so list addresses flow without bubbles.
module address_sequencer #(
    parameter int XBITS     = 4,
    parameter int YBITS     = 4,
    parameter int LISTDEPTH = 32,
    parameter int LISTBITS  = $clog2(LISTDEPTH)
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [LISTBITS:0]      listLength,
    input  logic                   listWrEn,
    input  logic [LISTBITS-1:0]    listWrIndex,
    input  logic [XBITS-1:0]       listWrX,
    input  logic [YBITS-1:0]       listWrY,
    input  logic                   storageReady,
    output logic [XBITS+YBITS-1:0] address,
    output logic                   newAddress,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            passCount
);

    localparam int AW = XBITS + YBITS;
    localparam int IW = (AW > LISTBITS) ? AW : LISTBITS;
    localparam logic [IW-1:0]     LINEARLAST = IW'({AW{1'b1}});
    localparam logic [LISTBITS:0] DEPTHVAL   = (LISTBITS+1)'(LISTDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateType;

    stateType          state;
    logic [IW-1:0]     index;
    logic              modeList;
    logic              modeRepeat;
    logic [LISTBITS:0] lenLatched;

    // List storage is deliberately unreset so programmed lists survive resetN.
    logic [XBITS-1:0] listX [LISTDEPTH];
    logic [YBITS-1:0] listY [LISTDEPTH];

    logic              handshake;
    logic              lastElem;
    logic [IW-1:0]     listLast;
    logic [IW-1:0]     nextIndex;
    logic [AW-1:0]     nextElem;
    logic [AW-1:0]     firstElem;
    logic [LISTBITS:0] lenSat;
    logic [LISTBITS:0] lenMinusOne;

    always_ff @(posedge clock) begin
        if (state == IDLE && listWrEn) begin
            listX[listWrIndex] <= listWrX;
            listY[listWrIndex] <= listWrY;
        end
    end

    always_comb begin
        handshake   = newAddress & storageReady;
        lenMinusOne = lenLatched - 1'b1;
        listLast    = IW'(lenMinusOne);
        lastElem    = (index == (modeList ? listLast : LINEARLAST));
        nextIndex   = lastElem ? '0 : index + 1'b1;
        nextElem    = modeList ? {listX[nextIndex[LISTBITS-1:0]], listY[nextIndex[LISTBITS-1:0]]}
                               : nextIndex[AW-1:0];
        firstElem   = mode[0] ? {listX[0], listY[0]} : '0;
        lenSat      = (listLength > DEPTHVAL) ? DEPTHVAL : listLength;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            index      <= '0;
            address    <= '0;
            newAddress <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            passCount  <= '0;
            modeList   <= 1'b0;
            modeRepeat <= 1'b0;
            lenLatched <= '0;
        end else begin
            case (state)
                IDLE: begin
                    newAddress <= 1'b0;
                    done       <= 1'b0;
                    if (start && !abort) begin
                        modeList   <= mode[0];
                        modeRepeat <= mode[1];
                        lenLatched <= lenSat;
                        index      <= '0;
                        passCount  <= '0;
                        busy       <= 1'b1;
                        if (mode[0] && listLength == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            newAddress <= 1'b1;
                            address    <= firstElem;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        newAddress <= 1'b0;
                        busy       <= 1'b0;
                    end else if (handshake) begin
                        index <= nextIndex;
                        if (lastElem) begin
                            passCount <= passCount + 16'd1;
                            if (modeRepeat) begin
                                address <= nextElem;
                            end else begin
                                state      <= DONE;
                                newAddress <= 1'b0;
                                done       <= 1'b1;
                            end
                        end else begin
                            address <= nextElem;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    newAddress <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    newAddress <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/address_sequencer.md
# address_sequencer

Parametrised address generator feeding the pattern memory's storage port: it walks either a full linear sweep of the {x, y} address space or a programmable list of (x, y) positions, one address per ready/valid handshake. It supports single-pass and repeating modes, runtime list loading, abort, and pass counting. It sits between the control sequencer and the memory write/read logic.

## Interface
Parameters:
- XBITS, 4, width of x coordinate (upper address field)
- YBITS, 4, width of y coordinate (lower address field)
- LISTDEPTH, 32, number of list entries (power of two, ≥2)
- LISTBITS, $clog2(LISTDEPTH), list index width

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetN  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate run; sampled in every state
- mode  in  2  bit0: 0 = linear, 1 = list; bit1: 0 = single pass, 1 = repeat; latched on start
- listLength  in  LISTBITS+1  entries used in list mode (0..LISTDEPTH); latched on start
- listWrEn  in  1  list write strobe; honoured only in IDLE
- listWrIndex  in  LISTBITS  list write index
- listWrX  in  XBITS  x value written
- listWrY  in  YBITS  y value written
- storageReady  in  1  downstream ready
- address  out  XBITS+YBITS  current address {x, y}
- newAddress  out  1  address valid
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at normal completion
- passCount  out  16  completed passes in current run, wraps at 2^16

## Operation
- States: IDLE, RUN, DONE.
- IDLE: newAddress=0. List writes are accepted. start=1 and abort=0 latch mode and listLength, clear the index and passCount, and go to RUN.
  - In list mode with listLength=0, go to DONE instead. No address is issued.
  - listLength > LISTDEPTH saturates to LISTDEPTH.
- RUN: newAddress=1.
  - address = index (linear) or {listX[index], listY[index]} (list).
  - Handshake = newAddress & storageReady. On a handshake, index advances. With no handshake, address and newAddress hold stable.
  - Last element = index of 2^(XBITS+YBITS)-1 (linear) or listLength-1 (list).
  - Handshake on the last element:
    - passCount increments.
    - Single-pass modes go to DONE.
    - Repeat modes wrap index to 0 and stay in RUN with no bubble.
- DONE: exactly one cycle. done=1, newAddress=0, busy=1. Then go to IDLE.
- abort=1 in RUN or DONE: go to IDLE next cycle.
  - newAddress=0, done is not pulsed, passCount is held.
  - A handshake in the same cycle completes downstream, but no further address is issued.
- abort and start together in IDLE: abort wins; remain in IDLE.
- start while not in IDLE is ignored. listWrEn outside IDLE is ignored.
- The list RAM is not reset. Its contents persist across runs and across resetN.
- Reset values: state=IDLE, address=0, newAddress=0, busy=0, done=0, passCount=0, index=0. Reset mid-run drops newAddress immediately (asynchronous).

## Timing
- start accepted at edge N: newAddress=1 with the first address after edge N.
- Back-to-back: storageReady held high gives one new address per cycle. Address k is valid in cycle N+1+k.
- Last handshake at edge M (single pass): done=1 in cycle M+1. busy=0 and IDLE from M+2. The next start is accepted at edge M+2.
- List read: registered list RAM read with the next index prefetched. No bubble between consecutive list addresses.
- List write at edge W is visible to a start at edge W+1.
- Wrap in repeat mode is seamless: the last and first addresses occupy consecutive cycles.

## Test plan
- Reset then linear single pass (XBITS=YBITS=4), storageReady=1 → addresses 0x00..0xFF on 256 consecutive cycles; done pulse one cycle after 0xFF; passCount=1.
- Load list (0,4),(13,0),(1,15),(2,11); listLength=4; list single pass; storageReady toggling 1,0,1,0 → addresses 0x04,0xD0,0x1F,0x2B, each held while ready=0; no duplicates or skips; done once.
- List repeat, listLength=3, 10 handshakes → sequence wraps with no bubble (e0,e1,e2,e0,…); passCount=3; abort at handshake 10 → IDLE next cycle, done not pulsed, passCount stays 3.
- listLength=0 in list mode → newAddress never asserted; done pulsed in the cycle after start. listLength=40 with LISTDEPTH=32 → 32 addresses issued.
- start during RUN, and listWrEn during RUN → both ignored; sequence and list contents unchanged. abort+start together in IDLE → stays IDLE.
- resetN asserted mid-run → newAddress, busy, and done drop to 0 asynchronously; after release the previous list is intact and a new list run replays it.
